// File: rtl/dvp_pattern_tx.sv
// dvp_pattern_tx: OV7670-style DVP sensor emulator, RGB565 test patterns, high byte first.
// Define DVP_TX_FRAME_STAMP_EN to replace pixel (0,0) of each frame with the frame counter.
module dvp_pattern_tx #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enable,
    input  logic [1:0]  i_pattern_sel,
    output logic        o_vsync,
    output logic        o_href,
    output logic [7:0]  o_data,
    output logic [15:0] o_frame_cnt,
    output logic        o_busy
);
    localparam int L    = 2 * H_ACTIVE + H_BLANK;
    localparam int VM0  = VSYNC_LINES > V_BACK ? VSYNC_LINES : V_BACK;
    localparam int VM1  = V_ACTIVE > V_FRONT ? V_ACTIVE : V_FRONT;
    localparam int VMAX = VM0 > VM1 ? VM0 : VM1;
    localparam int HW   = $clog2(L);
    localparam int VW   = $clog2(VMAX + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VSYNC  = 3'd1;
    localparam logic [2:0] S_VBACK  = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_VFRONT = 3'd4;

    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    logic [2:0]    state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] ln_q, ln_d;
    logic [1:0]    pat_q, pat_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          vsync_q, href_q, busy_q;
    logic [7:0]    data_q;
    logic          vsync_d, href_d, busy_d;
    logic [7:0]    data_d;
    logic          last_h, last_ln;
    logic [15:0]   x, bar, pat_pix, pix;
    logic          y5;

    function automatic logic [VW-1:0] last_line(input logic [2:0] s);
        return s == S_VSYNC  ? VW'(VSYNC_LINES - 1) :
               s == S_VBACK  ? VW'(V_BACK - 1) :
               s == S_ACTIVE ? VW'(V_ACTIVE - 1) : VW'(V_FRONT - 1);
    endfunction

    assign last_h  = h_q == HW'(L - 1);
    assign last_ln = ln_q == last_line(state_q);

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        ln_d    = ln_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        if (state_q == S_IDLE) begin
            if (i_enable) begin
                state_d = S_VSYNC;
                pat_d   = i_pattern_sel;
            end
        end else begin
            h_d = last_h ? '0 : h_q + 1'b1;
            if (last_h) begin
                ln_d = last_ln ? '0 : ln_q + 1'b1;
                if (last_ln) begin
                    case (state_q)
                        S_VSYNC:  state_d = S_VBACK;
                        S_VBACK:  state_d = S_ACTIVE;
                        S_ACTIVE: state_d = S_VFRONT;
                        default: begin
                            cnt_d   = cnt_q + 16'd1;
                            state_d = i_enable ? S_VSYNC : S_IDLE;
                            pat_d   = i_enable ? i_pattern_sel : pat_q;
                        end
                    endcase
                end
            end
        end
    end

    // Outputs are derived from the next-state position so they register in step with the FSM.
    always_comb begin
        x       = 16'(h_d >> 1);
        y5      = |(16'(ln_d) & 16'h0020);
        bar     = x / 16'(H_ACTIVE / 8);
        pat_pix = pat_d == 2'd1 ? 16'h07E0 :
                  pat_d == 2'd2 ? {x[9:5], x[9:4], x[9:5]} :
                  pat_d == 2'd3 ? ((x[5] ^ y5) ? 16'hFFFF : 16'h0000) : BARS[bar[2:0]];
`ifdef DVP_TX_FRAME_STAMP_EN
        pix     = (x == 16'd0 && ln_d == '0) ? cnt_d : pat_pix;
`else
        pix     = pat_pix;
`endif
        vsync_d = state_d == S_VSYNC;
        href_d  = state_d == S_ACTIVE && h_d < HW'(2 * H_ACTIVE);
        data_d  = href_d ? (h_d[0] ? pix[7:0] : pix[15:8]) : 8'h00;
        busy_d  = state_d != S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            h_q     <= '0;
            ln_q    <= '0;
            pat_q   <= '0;
            cnt_q   <= '0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            ln_q    <= ln_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    assign o_vsync     = vsync_q;
    assign o_href      = href_q;
    assign o_data      = data_q;
    assign o_frame_cnt = cnt_q;
    assign o_busy      = busy_q;
endmodule
